// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads 16 big-endian words, then streams W[0..63]
// from a sliding 16-word window, computing each new word as the window shifts.
//
// state | meaning
// LOAD  | accepting message words into w[cnt], in_ready = 1
// EMIT  | presenting W[t] = w[0], advancing the window on each handshake
module sha256_msg_schedule (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_word,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_w,
    output logic [5:0]  out_idx,
    output logic        out_last
);

    typedef enum logic {
        LOAD = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] w [16];
    logic [3:0]  cnt;
    logic [5:0]  t;
    logic [31:0] w_next;

    function automatic logic [31:0] sig0(input logic [31:0] x);
        sig0 = {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        sig1 = {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    // Single-cycle four-operand sum; carries out of bit 31 are dropped.
    assign w_next = sig1(w[14]) + w[9] + sig0(w[1]) + w[0];

    assign in_ready  = (state == LOAD);
    assign out_valid = (state == EMIT);
    assign out_w     = w[0];
    assign out_idx   = t;
    assign out_last  = (state == EMIT) && (t == 6'd63);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD;
            cnt   <= 4'd0;
            t     <= 6'd0;
            for (int i = 0; i < 16; i++) begin
                w[i] <= 32'd0;
            end
        end else begin
            case (state)
                LOAD: begin
                    if (in_valid) begin
                        w[cnt] <= in_word;
                        cnt    <= cnt + 4'd1;
                        if (cnt == 4'd15) begin
                            state <= EMIT;
                            t     <= 6'd0;
                        end
                    end
                end
                EMIT: begin
                    // Words produced after t = 47 are never presented; the update runs anyway.
                    if (out_ready) begin
                        for (int i = 0; i < 15; i++) begin
                            w[i] <= w[i+1];
                        end
                        w[15] <= w_next;
                        t     <= t + 6'd1;
                        if (t == 6'd63) begin
                            state <= LOAD;
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: doc/sha256_msg_schedule.md
# sha256_msg_schedule

Generates the SHA-256 message schedule W[0..63] for one 512-bit block. It accepts the 16 big-endian message words over a valid/ready input stream and emits the 64 schedule words, one per handshake, to the compression round logic. It is the word-supply end of the round datapath that consumes the Sigma0/Sigma1 round functions. A sliding 16-word window holds the state, and each new word is computed as it is emitted.

## Interface
- No parameters; word width fixed at 32, block fixed at 16 input / 64 output words.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_word is valid
- in_ready  output  1  block accepts in_word this cycle
- in_word  input  32  message word, M[0] first, big-endian as in FIPS 180-4
- out_valid  output  1  out_w holds W[out_idx]
- out_ready  input  1  consumer takes out_w this cycle
- out_w  output  32  schedule word W[t]
- out_idx  output  6  round index t, 0..63
- out_last  output  1  high with out_valid when t = 63

## Operation
- The clock domain is clk only. Reset is asynchronous and active-low.
- Two states:
  - LOAD (reset state): in_ready = 1 and out_valid = 0.
  - EMIT: in_ready = 0 and out_valid = 1.
- Storage: window w[0..15] of 32-bit registers, a 4-bit load counter and a 6-bit emit counter t.
- LOAD: each in_valid&in_ready writes in_word to w[cnt] and increments cnt. The accept that makes cnt = 16 moves the block to EMIT with t = 0 and clears cnt.
- EMIT outputs:
  - out_w = w[0]
  - out_idx = t
  - out_last = (t == 63)
- EMIT, on each out_valid&out_ready:
  - shift the window: w[i] <= w[i+1] for i = 0..14
  - w[15] <= σ1(w[14]) + w[9] + σ0(w[1]) + w[0], all additions modulo 2^32 with carries discarded
  - t <= t+1
- σ0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x).
- σ1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
- ROTR is a cyclic rotate; SHR is a logical shift with zero fill.
- Words computed for t ≥ 48 are never emitted. This is permitted, and the update is not gated.
- Handshake on t = 63 returns the block to LOAD; the next block may be accepted on the following cycle.
- Stall: while out_valid & !out_ready, out_w, out_idx, out_last and the window hold unchanged.
- in_valid during EMIT is ignored, since in_ready = 0; no word is consumed.
- Reset mid-block, in either state, discards all progress. The block returns to LOAD with cnt = 0 and t = 0.

## Timing
- Reset values:
  - in_ready = 1, out_valid = 0, out_last = 0
  - out_w = 0, out_idx = 0
  - window and counters = 0
- in_ready and out_valid decode from registered state only; there is no combinational path from in_valid or out_ready.
- out_w, out_idx and out_last are registered or come straight from registers.
- Latency: out_valid rises in the cycle after the 16th input accept, presenting W[0] = M[0].
- Throughput:
  - 1 input word per cycle in LOAD
  - 1 output word per cycle in EMIT with out_ready held high
  - 16 + 64 = 80 cycles per block minimum
- Gaps in in_valid are allowed and the load counter simply waits. Gaps in out_ready stall emission indefinitely.
- The critical path is σ0 + σ1 + a 4-operand 32-bit add in one cycle. A single-cycle adder tree is required; no internal pipelining.

## Test plan
- Reset: assert rst_n = 0 mid-cycle, asynchronously → all outputs reach their reset values immediately. Release → in_ready = 1 and out_valid = 0.
- "abc" block: load 0x61626380, fourteen × 0x00000000, then 0x00000018 at one word per cycle, with out_ready = 1. Required response:
  - W[0] = 0x61626380 and W[15] = 0x00000018
  - W[16] = 0x61626380 and W[17] = 0x000F0000
  - W[63] = 0x12B1EDEB, with out_last = 1 only at idx 63
  - in_ready = 1 on the following cycle
- Backpressure: same block with out_ready toggled pseudo-randomly → the identical W sequence. out_w and out_idx hold stable during every stall cycle.
- Input gaps and ignored input: insert random in_valid gaps during LOAD, and drive in_valid = 1 with garbage during EMIT → the W sequence is unchanged and no garbage word is consumed.
- Wrap-around arithmetic: load all 16 words as 0xFFFFFFFF → W[16] = σ1(0xFFFFFFFF) + 0xFFFFFFFF + σ0(0xFFFFFFFF) + 0xFFFFFFFF mod 2^32 = 0x003FFFFF + 0xFFFFFFFF + 0x1FFFFFFF + 0xFFFFFFFF = 0x203FFFFC.
- Reset mid-operation:
  - Assert rst_n at W[30] during EMIT, then load the "abc" block → the full correct sequence from W[0].
  - Assert rst_n after 7 loaded words in LOAD → the next 16 words form a fresh block.
